// File: rtl/nextz80_bus_pkg.sv
// Shared types for the NextZ80 bus controller.
// Contents: bus FSM state enum, address space enum, and the width of the
// wait-state counter.
package nextz80_bus_pkg;

    localparam int unsigned WS_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } bus_state_e;

    typedef enum logic {
        MEM,
        IO
    } space_e;

endpackage

// File: rtl/nextz80_sync.sv
// N-stage flop synchroniser for asynchronous board inputs.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, loads RESET_VAL into every stage
//   d    - asynchronous input
//   q    - synchronised output (STAGES cycles of latency)
module nextz80_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/nextz80_bus_ctrl.sv
// Bus controller between the NextZ80 core and the board pins.
// Turns the core's single-cycle MREQ/IORQ/WR handshake into a timed external
// bus cycle (SETUP, STROBE with per-space wait states, DONE), honours the
// external WAIT pin and synchronises INT/NMI into the core clock domain.
// Ports:
//   CLK, RESET                       - core clock, async active-high reset
//   core_addr/do/di/wr/mreq/iorq/m1  - core side bus
//   core_wait                        - stall to core
//   core_int, core_nmi               - interrupt requests to core
//   bank                             - upper address bits, sampled at accept
//   ext_addr, ext_d_o/oe/i           - external address and data bus
//   ext_rd_n .. ext_m1_n             - external active-low strobes
//   ext_wait_n, ext_int_n, ext_nmi_n - asynchronous board inputs
module nextz80_bus_ctrl
    import nextz80_bus_pkg::*;
#(
    parameter int unsigned MEM_WS      = 1,
    parameter int unsigned IO_WS       = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                                        CLK,
    input  logic                                        RESET,
    input  logic [15:0]                                 core_addr,
    input  logic [7:0]                                  core_do,
    output logic [7:0]                                  core_di,
    input  logic                                        core_wr,
    input  logic                                        core_mreq,
    input  logic                                        core_iorq,
    input  logic                                        core_m1,
    output logic                                        core_wait,
    output logic                                        core_int,
    output logic                                        core_nmi,
    // Kept one bit wide when ADDR_W == 16 so the port is never zero width.
    input  logic [((ADDR_W > 16) ? ADDR_W - 16 : 1)-1:0] bank,
    output logic [ADDR_W-1:0]                           ext_addr,
    output logic [7:0]                                  ext_d_o,
    output logic                                        ext_d_oe,
    input  logic [7:0]                                  ext_d_i,
    output logic                                        ext_rd_n,
    output logic                                        ext_wr_n,
    output logic                                        ext_mreq_n,
    output logic                                        ext_iorq_n,
    output logic                                        ext_m1_n,
    input  logic                                        ext_wait_n,
    input  logic                                        ext_int_n,
    input  logic                                        ext_nmi_n
);

    localparam logic [WS_W-1:0] MemWsInit = WS_W'(MEM_WS);
    localparam logic [WS_W-1:0] IoWsInit  = WS_W'(IO_WS);

    bus_state_e       state;
    space_e           space_q;
    logic [WS_W-1:0]  cnt;
    logic             wr_q;
    logic             m1_q;
    logic [7:0]       rdata;
    logic [ADDR_W-1:0] full_addr;
    logic             request;
    logic             wait_s, int_s, nmi_s;
    logic             nmi_prev;
    logic             nmi_edge;

    nextz80_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wait (
        .clk (CLK),
        .rst (RESET),
        .d   (ext_wait_n),
        .q   (wait_s)
    );

    nextz80_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_int (
        .clk (CLK),
        .rst (RESET),
        .d   (ext_int_n),
        .q   (int_s)
    );

    nextz80_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nmi (
        .clk (CLK),
        .rst (RESET),
        .d   (ext_nmi_n),
        .q   (nmi_s)
    );

    if (ADDR_W > 16) begin : g_bank
        assign full_addr = {bank, core_addr};
    end else begin : g_no_bank
        logic unused_bank;
        assign unused_bank = ^bank;
        assign full_addr   = core_addr;
    end

    assign request = core_mreq | core_iorq;

    // Combinational in IDLE so the core stalls in the very cycle it asks.
    assign core_wait = ~RESET & (state != DONE) & ((state != IDLE) | request);
    assign core_di   = rdata;
    assign core_int  = ~int_s;
    assign nmi_edge  = nmi_prev & ~nmi_s;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            space_q    <= MEM;
            cnt        <= '0;
            wr_q       <= 1'b0;
            m1_q       <= 1'b0;
            rdata      <= '0;
            ext_addr   <= '0;
            ext_d_o    <= '0;
            ext_d_oe   <= 1'b0;
            ext_rd_n   <= 1'b1;
            ext_wr_n   <= 1'b1;
            ext_mreq_n <= 1'b1;
            ext_iorq_n <= 1'b1;
            ext_m1_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state      <= SETUP;
                        // IORQ wins when both are set (interrupt acknowledge).
                        space_q    <= core_iorq ? IO : MEM;
                        cnt        <= core_iorq ? IoWsInit : MemWsInit;
                        wr_q       <= core_wr;
                        m1_q       <= core_m1;
                        ext_addr   <= full_addr;
                        ext_d_o    <= core_do;
                        ext_d_oe   <= core_wr;
                        ext_mreq_n <= core_iorq;
                        ext_iorq_n <= ~core_iorq;
                        ext_m1_n   <= ~core_m1;
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    ext_rd_n <= wr_q;
                    ext_wr_n <= ~wr_q;
                end
                STROBE: begin
                    if (cnt == '0 && wait_s) begin
                        state      <= DONE;
                        ext_rd_n   <= 1'b1;
                        ext_wr_n   <= 1'b1;
                        ext_mreq_n <= 1'b1;
                        ext_iorq_n <= 1'b1;
                        ext_m1_n   <= 1'b1;
                        if (!wr_q) begin
                            rdata <= ext_d_i;
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Data was held through DONE for write hold time.
                    ext_d_oe <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            nmi_prev <= 1'b1;
            core_nmi <= 1'b0;
        end else begin
            nmi_prev <= nmi_s;
            // A fresh edge takes priority over the clear.
            if (nmi_edge) begin
                core_nmi <= 1'b1;
            end else if (state == DONE && m1_q && space_q == MEM) begin
                core_nmi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nextz80_bus_ctrl.sv
module tb_nextz80_bus_ctrl;

    localparam int unsigned MEM_WS      = 1;
    localparam int unsigned IO_WS       = 2;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned SYNC_STAGES = 2;

    logic        CLK;
    logic        RESET;
    logic [15:0] core_addr;
    logic [7:0]  core_do;
    logic [7:0]  core_di;
    logic        core_wr, core_mreq, core_iorq, core_m1;
    logic        core_wait, core_int, core_nmi;
    logic [0:0]  bank;
    logic [15:0] ext_addr;
    logic [7:0]  ext_d_o;
    logic        ext_d_oe;
    logic [7:0]  ext_d_i;
    logic        ext_rd_n, ext_wr_n, ext_mreq_n, ext_iorq_n, ext_m1_n;
    logic        ext_wait_n, ext_int_n, ext_nmi_n;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [7:0] di;
        int         wait_cyc;
        logic       is_read;
    } exp_t;

    exp_t sb[$];

    nextz80_bus_ctrl #(
        .MEM_WS      (MEM_WS),
        .IO_WS       (IO_WS),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .core_addr  (core_addr),
        .core_do    (core_do),
        .core_di    (core_di),
        .core_wr    (core_wr),
        .core_mreq  (core_mreq),
        .core_iorq  (core_iorq),
        .core_m1    (core_m1),
        .core_wait  (core_wait),
        .core_int   (core_int),
        .core_nmi   (core_nmi),
        .bank       (bank),
        .ext_addr   (ext_addr),
        .ext_d_o    (ext_d_o),
        .ext_d_oe   (ext_d_oe),
        .ext_d_i    (ext_d_i),
        .ext_rd_n   (ext_rd_n),
        .ext_wr_n   (ext_wr_n),
        .ext_mreq_n (ext_mreq_n),
        .ext_iorq_n (ext_iorq_n),
        .ext_m1_n   (ext_m1_n),
        .ext_wait_n (ext_wait_n),
        .ext_int_n  (ext_int_n),
        .ext_nmi_n  (ext_nmi_n)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends DONE.
    // Pad WAIT is held low for cycles 1..wait_len, counting the accept cycle as 0.
    task automatic run_access(input string tag, input logic mreq, input logic iorq,
                              input logic wr, input logic m1, input logic [15:0] addr,
                              input logic [7:0] dout, input logic [7:0] din,
                              input int wait_len);
        int   ws;
        int   n_wait, n_rd, n_wr, n_mreq, n_iorq, n_m1, n_oe;
        logic [15:0] seen_addr;
        logic [7:0]  seen_do, got_di;
        bit   done;
        exp_t e;
        ws         = iorq ? int'(IO_WS) : int'(MEM_WS);
        e.di       = din;
        e.wait_cyc = ws + 3 + wait_len;
        e.is_read  = !wr;
        sb.push_back(e);
        n_wait = 0; n_rd = 0; n_wr = 0; n_mreq = 0; n_iorq = 0; n_m1 = 0; n_oe = 0;
        seen_addr = '0; seen_do = '0; got_di = '0; done = 0;
        ext_d_i   = din;
        core_addr = addr;
        core_do   = dout;
        core_wr   = wr;
        core_m1   = m1;
        core_mreq = mreq;
        core_iorq = iorq;
        for (int idx = 0; idx < 60 && !done; idx++) begin
            @(negedge CLK);
            if (core_wait)   n_wait++;
            if (!ext_rd_n)   n_rd++;
            if (!ext_wr_n)   n_wr++;
            if (!ext_mreq_n) n_mreq++;
            if (!ext_iorq_n) n_iorq++;
            if (!ext_m1_n)   n_m1++;
            if (ext_d_oe) begin
                n_oe++;
                seen_do = ext_d_o;
            end
            if (!ext_mreq_n || !ext_iorq_n) seen_addr = ext_addr;
            if (!core_wait) begin
                done   = 1;
                got_di = core_di;
            end
            @(posedge CLK);
            #1;
            ext_wait_n = !(idx + 1 >= 1 && idx + 1 <= wait_len);
        end
        core_mreq  = 1'b0;
        core_iorq  = 1'b0;
        core_wr    = 1'b0;
        core_m1    = 1'b0;
        ext_wait_n = 1'b1;
        if (!done) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check({tag, "_wait_cyc"}, n_wait, e.wait_cyc);
        if (e.is_read) begin
            check({tag, "_di"}, got_di, e.di);
            check({tag, "_rd_low"}, n_rd, ws + 1 + wait_len);
            check({tag, "_wr_low"}, n_wr, 0);
            check({tag, "_oe"}, n_oe, 0);
        end else begin
            check({tag, "_wr_low"}, n_wr, ws + 1 + wait_len);
            check({tag, "_rd_low"}, n_rd, 0);
            check({tag, "_oe"}, n_oe, ws + 3 + wait_len);
            check({tag, "_do"}, seen_do, dout);
        end
        check({tag, "_iorq_low"}, n_iorq, iorq ? ws + 2 + wait_len : 0);
        check({tag, "_mreq_low"}, n_mreq, iorq ? 0 : ws + 2 + wait_len);
        check({tag, "_m1_low"}, n_m1, m1 ? ws + 2 + wait_len : 0);
        check({tag, "_addr"}, seen_addr, addr);
    endtask

    initial begin
        int cnt;
        RESET      = 1'b1;
        core_addr  = '0;
        core_do    = '0;
        core_wr    = 1'b0;
        core_mreq  = 1'b0;
        core_iorq  = 1'b0;
        core_m1    = 1'b0;
        bank       = '0;
        ext_d_i    = '0;
        ext_wait_n = 1'b1;
        ext_int_n  = 1'b1;
        ext_nmi_n  = 1'b1;

        #12;
        check("rst_strobes", {ext_rd_n, ext_wr_n, ext_mreq_n, ext_iorq_n, ext_m1_n}, 5'b11111);
        check("rst_oe", ext_d_oe, 1'b0);
        check("rst_addr", ext_addr, 16'h0);
        check("rst_do", ext_d_o, 8'h0);
        check("rst_di", core_di, 8'h0);
        check("rst_wait", core_wait, 1'b0);
        check("rst_int_nmi", {core_int, core_nmi}, 2'b00);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        run_access("mem_rd", 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5, 0);
        run_access("io_wr", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0045, 8'h3C, 8'h00, 0);
        run_access("mem_rd_wait", 1'b1, 1'b0, 1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h5A, 5);
        run_access("inta", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0038, 8'h00, 8'hFF, 0);
        run_access("mem_wr", 1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 8'hC3, 8'h00, 0);

        // INT level path.
        ext_int_n = 1'b0;
        @(posedge CLK);
        #1;
        check("int_early", core_int, 1'b0);
        @(posedge CLK);
        #1;
        check("int_set", core_int, 1'b1);
        ext_int_n = 1'b1;
        repeat (SYNC_STAGES) @(posedge CLK);
        #1;
        check("int_clr", core_int, 1'b0);

        // NMI edge latency, persistence across non-M1 cycles, clear on M1 fetch.
        ext_nmi_n = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            cnt++;
            if (core_nmi) break;
        end
        check("nmi_latency", cnt, SYNC_STAGES + 1);
        ext_nmi_n = 1'b1;
        run_access("nmi_io", 1'b0, 1'b1, 1'b0, 1'b0, 16'h00FE, 8'h00, 8'h11, 0);
        check("nmi_hold_io", core_nmi, 1'b1);
        run_access("nmi_mem", 1'b1, 1'b0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h22, 0);
        check("nmi_hold_mem", core_nmi, 1'b1);
        run_access("nmi_m1", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0066, 8'h00, 8'hED, 0);
        check("nmi_cleared", core_nmi, 1'b0);

        // Reset in the middle of STROBE.
        core_addr = 16'h2222;
        core_mreq = 1'b1;
        core_wr   = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        check("pre_rst_rd", ext_rd_n, 1'b0);
        RESET = 1'b1;
        #1;
        check("mid_rst_strobes", {ext_rd_n, ext_wr_n, ext_mreq_n, ext_iorq_n, ext_m1_n},
              5'b11111);
        check("mid_rst_wait", core_wait, 1'b0);
        @(posedge CLK);
        #1;
        core_mreq = 1'b0;
        RESET     = 1'b0;
        @(posedge CLK);
        #1;
        run_access("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 8'h00, 8'h77, 0);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
